// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RV32I load/store funct3 codes and access-size decode
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  function automatic logic [2:0] size_of(input logic [1:0] f);
    return f == 2'd0 ? 3'd1 : f == 2'd1 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask, store data positioning and load data extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  mask8,
  output logic [63:0] wdata64,
  output logic [31:0] rdata
);
  logic [2:0]  size;
  logic [7:0]  base;
  logic [31:0] sh;
  logic        sgn;
  assign size    = size_of(funct3[1:0]);
  assign base    = (8'd1 << size) - 8'd1;
  assign mask8   = base << off;
  assign wdata64 = {32'd0, wdata} << {off, 3'b000};
  assign sh      = 32'(rword >> {off, 3'b000});
  assign sgn     = ~funct3[2];
  assign rdata   = size == 3'd1 ? {{24{sgn & sh[7]}}, sh[7:0]}
                 : size == 3'd2 ? {{16{sgn & sh[15]}}, sh[15:0]}
                 : sh;
endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit issuing one or two word beats per access to a word memory
module lsu
  import lsu_pkg::*;
#(
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic        req_write,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_t      state, state_n;
  logic [31:0] addr_q, wdata_q, r0, r1, ldata;
  logic [2:0]  f3_q, in_size;
  logic        write_q, beat, err_q, misalign, illegal, accept, more;
  logic [7:0]  mask8;
  logic [63:0] w64;
  assign in_size   = size_of(req_funct3[1:0]);
  assign misalign  = 3'(req_addr[1:0]) + in_size > 3'd4;
  assign illegal   = (req_write ? !(req_funct3 inside {SB, SH, SW})
                                : !(req_funct3 inside {LB, LH, LW, LBU, LHU}))
                   || (MISALIGN_SPLIT == 0 && misalign);
  assign req_ready = rst_n && state == IDLE;
  assign accept    = req_valid && req_ready;
  assign more      = !beat && mask8[7:4] != 4'd0;
  lsu_align u_align (
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .wdata  (wdata_q),
    .rword  ({r1, r0}),
    .mask8  (mask8),
    .wdata64(w64),
    .rdata  (ldata)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  // next state: illegal requests skip straight to the response cycle
  always_comb begin
    state_n = state == IDLE ? (accept ? (illegal ? DONE : REQ) : IDLE)
            : state == REQ  ? (mem_gnt ? WAIT : REQ)
            : state == WAIT ? (mem_rvalid ? (more ? REQ : DONE) : WAIT)
            : IDLE;
  end
  // request capture and per-beat read data capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      beat    <= 1'b0;
      r0      <= '0;
      r1      <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        write_q <= req_write;
        err_q   <= illegal;
        beat    <= 1'b0;
        r0      <= '0;
        r1      <= '0;
      end
      if (state == WAIT && mem_rvalid) begin
        if (beat) r1 <= mem_rdata;
        else      r0 <= mem_rdata;
        if (more) beat <= 1'b1;
      end
    end
  assign mem_req    = state == REQ;
  assign mem_we     = mem_req && write_q;
  assign mem_addr   = mem_req ? {addr_q[31:2] + 30'(beat), 2'b00} : 32'd0;
  assign mem_be     = mem_req ? (beat ? mask8[7:4] : mask8[3:0]) : 4'd0;
  assign mem_wdata  = mem_we ? (beat ? w64[63:32] : w64[31:0]) : 32'd0;
  assign resp_valid = state == DONE;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid && !err_q && !write_q ? ldata : 32'd0;
endmodule
